// File: rtl/alu_cmd_sequencer.sv
// Two-requester round-robin command sequencer that owns the regfile/ALU datapath controls.
// Each accepted instruction is decoded, held for a settle period, then written in one cycle.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  NOP_OP        = 8'h00,
  parameter logic [7:0]  CMP_OP        = 8'h0B,
  parameter logic [7:0]  CMPI_OP       = 8'hB0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_inst,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_inst,
  output logic        req1_ready,
  output logic [15:0] regEn,
  output logic [3:0]  muxA,
  output logic [3:0]  muxB,
  output logic        muxBimm,
  output logic [7:0]  Opcode,
  output logic [7:0]  imm,
  output logic        flagEn,
  output logic        busy,
  output logic        done,
  output logic        done_id
);

  localparam int unsigned CntLastInt = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [3:0]  CntLast    = 4'(CntLastInt);

  typedef enum logic [1:0] {StIdle, StSettle, StWrite} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] inst_q, inst_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;

  logic        grant0, grant1, accept;
  logic [3:0]  op;
  logic [7:0]  dec_opcode;
  logic        no_write;

  // Round-robin: on contention the requester that did not win last time is granted.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
    accept = (state_q == StIdle) && (grant0 || grant1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      inst_q       <= 16'h0000;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    inst_d       = inst_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          inst_d       = grant1 ? req1_inst : req0_inst;
          owner_d      = grant1;
          last_grant_d = grant1;
          cnt_d        = 4'd0;
          state_d      = (SETTLE_CYCLES == 0) ? StWrite : StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == CntLast) begin
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op         = inst_q[15:12];
    dec_opcode = (op == 4'b0000) ? {4'b0000, inst_q[7:4]} : {op, 4'b0000};
    no_write   = (dec_opcode == NOP_OP) || (dec_opcode == CMP_OP) || (dec_opcode == CMPI_OP);
  end

  // Reset overrides everything so no write or flag pulse escapes during the rst cycle.
  always_comb begin
    regEn      = 16'h0000;
    muxA       = 4'h0;
    muxB       = 4'h0;
    muxBimm    = 1'b0;
    Opcode     = NOP_OP;
    imm        = 8'h00;
    flagEn     = 1'b0;
    done       = 1'b0;
    done_id    = 1'b0;
    busy       = !rst && (state_q != StIdle);
    req0_ready = !rst && (state_q == StIdle) && grant0;
    req1_ready = !rst && (state_q == StIdle) && grant1;
    if (!rst && (state_q != StIdle)) begin
      Opcode = dec_opcode;
      muxA   = inst_q[11:8];
      if (op == 4'b0000) begin
        muxB = inst_q[3:0];
      end else begin
        muxBimm = 1'b1;
        imm     = inst_q[7:0];
      end
      if (state_q == StWrite) begin
        regEn   = no_write ? 16'h0000 : (16'h0001 << inst_q[11:8]);
        flagEn  = (dec_opcode != NOP_OP);
        done    = 1'b1;
        done_id = owner_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: one instance with a one-cycle settle, one with none.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic        id;
    logic [15:0] regen;
    logic        flagen;
    logic [7:0]  op;
    logic [3:0]  ma;
    logic [3:0]  mb;
    logic        bimm;
    logic [7:0]  imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_r0v = 0, a_r1v = 0, a_r0r, a_r1r;
  logic [15:0] a_r0i = 0, a_r1i = 0, a_regen;
  logic [3:0]  a_ma, a_mb;
  logic [7:0]  a_op, a_imm;
  logic        a_bimm, a_flagen, a_busy, a_done, a_id;

  logic        b_r0v = 0, b_r1v = 0, b_r0r, b_r1r;
  logic [15:0] b_r0i = 0, b_r1i = 0, b_regen;
  logic [3:0]  b_ma, b_mb;
  logic [7:0]  b_op, b_imm;
  logic        b_bimm, b_flagen, b_busy, b_done, b_id;

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  alu_cmd_sequencer #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_r0v), .req0_inst(a_r0i), .req0_ready(a_r0r),
    .req1_valid(a_r1v), .req1_inst(a_r1i), .req1_ready(a_r1r),
    .regEn(a_regen), .muxA(a_ma), .muxB(a_mb), .muxBimm(a_bimm), .Opcode(a_op), .imm(a_imm),
    .flagEn(a_flagen), .busy(a_busy), .done(a_done), .done_id(a_id)
  );

  alu_cmd_sequencer #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_r0v), .req0_inst(b_r0i), .req0_ready(b_r0r),
    .req1_valid(b_r1v), .req1_inst(b_r1i), .req1_ready(b_r1r),
    .regEn(b_regen), .muxA(b_ma), .muxB(b_mb), .muxBimm(b_bimm), .Opcode(b_op), .imm(b_imm),
    .flagEn(b_flagen), .busy(b_busy), .done(b_done), .done_id(b_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic id, input logic [15:0] regen, input logic flagen,
                              input logic [7:0] op, input logic [3:0] ma, input logic [3:0] mb,
                              input logic bimm, input logic [7:0] imm);
    exp_t e;
    e = '{id: id, regen: regen, flagen: flagen, op: op, ma: ma, mb: mb, bimm: bimm, imm: imm};
    return e;
  endfunction

  function automatic logic rdy(input bit d, input bit p);
    return d ? (p ? b_r1r : b_r0r) : (p ? a_r1r : a_r0r);
  endfunction

  task automatic set_req(input bit d, input bit p, input logic v, input logic [15:0] inst);
    if (!d && !p) begin a_r0v = v; a_r0i = inst; end
    if (!d &&  p) begin a_r1v = v; a_r1i = inst; end
    if ( d && !p) begin b_r0v = v; b_r0i = inst; end
    if ( d &&  p) begin b_r1v = v; b_r1i = inst; end
  endtask

  // Called just after a falling edge; returns just after the accepting rising edge.
  task automatic send(input bit d, input bit p, input logic [15:0] inst);
    bit got = 0;
    set_req(d, p, 1'b1, inst);
    for (int i = 0; i < 50; i++) begin
      #1;
      if (rdy(d, p)) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no ready expected ready for inst %h", inst);
    end
    @(posedge clk);
    #1 set_req(d, p, 1'b0, inst);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (!a_busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    #1;
    if (a_done) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_done: got done=1 expected done=0 (regEn=%h)", a_regen);
      end else begin
        e = q_a.pop_front();
        check("a_done_pkt",
              64'({a_id, a_regen, a_flagen, a_op, a_ma, a_mb, a_bimm, a_imm}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    #1;
    if (b_done) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_done: got done=1 expected done=0 (regEn=%h)", b_regen);
      end else begin
        e = q_b.pop_front();
        check("b_done_pkt",
              64'({b_id, b_regen, b_flagen, b_op, b_ma, b_mb, b_bimm, b_imm}), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int acc;

    // Reset: outputs idle even with a request pending.
    @(negedge clk);
    @(negedge clk);
    a_r0v = 1;
    #1;
    check("rst_outputs", 64'({a_r0r, a_r1r, a_regen, a_op, a_flagen, a_busy, a_done, a_id}), 64'(0));
    @(negedge clk);
    rst = 0;
    a_r0v = 0;

    // Test 1: ADDI r0,#1 from req0.
    @(negedge clk);
    q_a.push_back(mk(1'b0, 16'h0001, 1'b1, 8'h50, 4'h0, 4'h0, 1'b1, 8'h01));
    a_r0i = 16'h5001;
    a_r0v = 1;
    #1 check("t1_ready_same_cycle", 64'(a_r0r), 64'(1));
    @(posedge clk);
    #1 a_r0v = 0;
    @(negedge clk);
    #1 check("t1_settle", 64'({a_ma, a_bimm, a_imm, a_op, a_regen}),
             64'({4'h0, 1'b1, 8'h01, 8'h50, 16'h0000}));
    @(negedge clk);
    #1 check("t1_write_done", 64'(a_done), 64'(1));
    @(negedge clk);
    #1 check("t1_idle_after", 64'({a_op, a_regen, a_flagen, a_busy, a_done}), 64'(0));

    // Test 2: ADD r3,r2 from req1.
    q_a.push_back(mk(1'b1, 16'h0008, 1'b1, 8'h05, 4'h3, 4'h2, 1'b0, 8'h00));
    send(1'b0, 1'b1, 16'h0352);
    @(negedge clk);
    #1 check("t2_settle", 64'({a_op, a_ma, a_mb, a_bimm}), 64'({8'h05, 4'h3, 4'h2, 1'b0}));
    wait_idle();

    // Test 3: both requesters held valid for 12 cycles.
    q_a.push_back(mk(1'b0, 16'h0002, 1'b1, 8'h10, 4'h1, 4'h0, 1'b1, 8'h23));
    q_a.push_back(mk(1'b1, 16'h0010, 1'b1, 8'h20, 4'h4, 4'h0, 1'b1, 8'h45));
    q_a.push_back(mk(1'b0, 16'h0002, 1'b1, 8'h10, 4'h1, 4'h0, 1'b1, 8'h23));
    q_a.push_back(mk(1'b1, 16'h0010, 1'b1, 8'h20, 4'h4, 4'h0, 1'b1, 8'h45));
    a_r0i = 16'h1123;
    a_r1i = 16'h2445;
    a_r0v = 1;
    a_r1v = 1;
    #1;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      check("t3_no_dual_ready", 64'(a_r0r & a_r1r), 64'(0));
      if (a_r0r || a_r1r) begin
        check("t3_grant_order", 64'(a_r1r), 64'(acc % 2));
        check("t3_accept_cycle", 64'(c), 64'(acc * 3));
        acc++;
      end
      @(negedge clk);
      #1;
    end
    a_r0v = 0;
    a_r1v = 0;
    check("t3_accept_count", 64'(acc), 64'(4));
    wait_idle();

    // Test 4: compares and NOP write no register.
    q_a.push_back(mk(1'b0, 16'h0000, 1'b1, 8'h0B, 4'h1, 4'h2, 1'b0, 8'h00));
    send(1'b0, 1'b0, 16'h01B2);
    wait_idle();
    q_a.push_back(mk(1'b1, 16'h0000, 1'b1, 8'hB0, 4'h1, 4'h0, 1'b1, 8'h23));
    send(1'b0, 1'b1, 16'hB123);
    wait_idle();
    q_a.push_back(mk(1'b0, 16'h0000, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 8'h00));
    send(1'b0, 1'b0, 16'h0000);
    wait_idle();

    // Test 5: reset during settle drops the instruction and restores req0 priority.
    send(1'b0, 1'b0, 16'h5207);
    @(negedge clk);
    #1 check("t5_in_settle", 64'(a_busy), 64'(1));
    rst = 1;
    a_r0v = 1;
    a_r0i = 16'h3001;
    #1 check("t5_rst_cycle", 64'({a_regen, a_flagen, a_done, a_busy, a_r0r}), 64'(0));
    @(posedge clk);
    #1 rst = 0;
    a_r0v = 0;
    @(negedge clk);
    #1 check("t5_idle_after_rst", 64'({a_regen, a_flagen, a_done, a_busy}), 64'(0));
    q_a.push_back(mk(1'b0, 16'h0001, 1'b1, 8'h30, 4'h0, 4'h0, 1'b1, 8'h01));
    q_a.push_back(mk(1'b1, 16'h0001, 1'b1, 8'h40, 4'h0, 4'h0, 1'b1, 8'h02));
    a_r0i = 16'h3001;
    a_r1i = 16'h4002;
    a_r0v = 1;
    a_r1v = 1;
    #1 check("t5_req0_first", 64'({a_r0r, a_r1r}), 64'(2'b10));
    @(posedge clk);
    #1 a_r0v = 0;
    @(negedge clk);
    send(1'b0, 1'b1, 16'h4002);
    wait_idle();

    // Test 6: zero settle; write follows accept directly, req1 stalls while busy.
    q_b.push_back(mk(1'b0, 16'h0400, 1'b1, 8'h50, 4'hA, 4'h0, 1'b1, 8'h0F));
    b_r0i = 16'h5A0F;
    b_r0v = 1;
    #1 check("t6_ready", 64'(b_r0r), 64'(1));
    @(posedge clk);
    #1 b_r0v = 0;
    b_r1i = 16'h6011;
    b_r1v = 1;
    @(negedge clk);
    #1 check("t6_write_next", 64'({b_regen, b_imm, b_done}), 64'({16'h0400, 8'h0F, 1'b1}));
    check("t6_req1_blocked", 64'({b_r1r, b_busy}), 64'(2'b01));
    q_b.push_back(mk(1'b1, 16'h0001, 1'b1, 8'h60, 4'h0, 4'h0, 1'b1, 8'h11));
    send(1'b1, 1'b1, 16'h6011);
    repeat (4) @(negedge clk);
    #2;
    check("q_a_drained", 64'(q_a.size()), 64'(0));
    check("q_b_drained", 64'(q_b.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
